mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared defaults and state type for the memory responder and its storage array.
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_INIT_VAL = '0;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word array with one write enable and a registered,
// read-enabled output that resets to a fixed value.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are never reset directly; the owner sweeps them during its init phase.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= RST_VAL;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: clears its array after reset, then serves single reads or
// writes per cycle, rejecting simultaneous read+write with a conflict pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = DEFAULT_INIT_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              conflict,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr, next_ptr;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              next_conflict;
  logic              wr_inc, rd_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      ptr      <= '0;
      ready    <= 1'b0;
      conflict <= 1'b0;
      wr_count <= 8'd0;
      rd_count <= 8'd0;
    end else begin
      state    <= next_state;
      ptr      <= next_ptr;
      ready    <= (next_state == RUN);
      conflict <= next_conflict;
      if (wr_inc) begin
        wr_count <= sat_inc(wr_count);
      end
      if (rd_inc) begin
        rd_count <= sat_inc(rd_count);
      end
    end
  end

  // Array port is owned by the init sweep in INIT and by the request ports in RUN.
  always_comb begin
    next_state    = state;
    next_ptr      = ptr;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_addr      = addr;
    mem_wdata     = data_in;
    next_conflict = 1'b0;
    wr_inc        = 1'b0;
    rd_inc        = 1'b0;
    if (rst_n) begin
      case (state)
        INIT: begin
          mem_we    = 1'b1;
          mem_addr  = ptr;
          mem_wdata = INIT_VAL;
          next_ptr  = ptr + ADDR_W'(1);
          if (ptr == LAST_WORD) begin
            next_state = RUN;
          end
        end
        RUN: begin
          if (read && write) begin
            next_conflict = 1'b1;
          end else if (write) begin
            mem_we = 1'b1;
            wr_inc = 1'b1;
          end else if (read) begin
            mem_re = 1'b1;
            rd_inc = 1'b1;
          end
        end
        default: begin
          next_state = INIT;
          next_ptr   = '0;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RST_VAL(INIT_VAL)
  ) u_mem_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the responder.
module tb_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       conflict;
  logic [7:0] wr_count;
  logic [7:0] rd_count;

  int total;
  int bad;

  logic [7:0] m_mem [32];
  logic [7:0] m_dout;
  int         m_wc;
  int         m_rc;
  int         m_init_left;
  logic       m_ready;
  logic       m_conf;

  mem_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .ready   (ready),
    .conflict(conflict),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: reset restarts a 32-cycle blackout that leaves memory all zero.
  task automatic modelStep(input logic rn, input logic r, input logic w,
                           input logic [4:0] a, input logic [7:0] d);
    if (!rn) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      m_init_left = 32;
      m_dout      = 8'h00;
      m_wc        = 0;
      m_rc        = 0;
      m_ready     = 1'b0;
      m_conf      = 1'b0;
    end else if (m_init_left > 0) begin
      m_init_left = m_init_left - 1;
      m_ready     = (m_init_left == 0);
      m_conf      = 1'b0;
    end else begin
      m_conf = r && w;
      if (r && w) begin
      end else if (w) begin
        m_mem[a] = d;
        if (m_wc < 255) m_wc = m_wc + 1;
      end else if (r) begin
        m_dout = m_mem[a];
        if (m_rc < 255) m_rc = m_rc + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic r, input logic w,
                               input logic [4:0] a, input logic [7:0] d);
    rst_n   = rn;
    read    = r;
    write   = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    modelStep(rn, r, w, a, d);
    #1;
    checkOutput("data_out", data_out, m_dout);
    checkOutput("ready", {7'd0, ready}, {7'd0, m_ready});
    checkOutput("conflict", {7'd0, conflict}, {7'd0, m_conf});
    checkOutput("wr_count", wr_count, 8'(m_wc));
    checkOutput("rd_count", rd_count, 8'(m_rc));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    m_init_left = 32;
    m_dout  = 8'h00;
    m_wc    = 0;
    m_rc    = 0;
    m_ready = 1'b0;
    m_conf  = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd9, 8'hC3);
    checkOutput("rst_dout", data_out, 8'h00);
    checkOutput("rst_ready", {7'd0, ready}, 8'h00);
    checkOutput("rst_wrcnt", wr_count, 8'h00);

    $display("[TB] init with read held");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'($urandom_range(0, 31)), 8'($urandom));
      checkOutput("init_ready", {7'd0, ready}, (i == 31) ? 8'd1 : 8'd0);
      checkOutput("init_rdcnt", rd_count, 8'h00);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 5'd17, 8'h00);
    checkOutput("read17_dout", data_out, 8'h00);
    checkOutput("read17_rdcnt", rd_count, 8'd1);

    applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 8'h41);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 8'h00);
    checkOutput("raw_dout", data_out, 8'h41);
    checkOutput("raw_wrcnt", wr_count, 8'd1);
    checkOutput("raw_rdcnt", rd_count, 8'd2);

    $display("[TB] conflict");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 8'h5A);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 8'hFF);
    checkOutput("conf_pulse", {7'd0, conflict}, 8'd1);
    checkOutput("conf_dout", data_out, 8'h41);
    checkOutput("conf_wrcnt", wr_count, 8'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd7, 8'h00);
    checkOutput("conf_once", {7'd0, conflict}, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 8'h00);
    checkOutput("conf_mem7", data_out, 8'h5A);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 8'($urandom));
    end

    $display("[TB] counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'($urandom_range(0, 31)), 8'($urandom));
    end
    checkOutput("wr_sat", wr_count, 8'd255);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'($urandom_range(0, 31)), 8'h00);
    end
    checkOutput("rd_sat", rd_count, 8'd255);
    checkOutput("wr_hold", wr_count, 8'd255);

    $display("[TB] reset clears memory");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd31, 8'h99);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 8'($urandom));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd31, 8'h00);
    checkOutput("clr31_dout", data_out, 8'h00);

    $display("[TB] reset during init");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 8'hAB);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 8'h77);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 8'h00);
    checkOutput("midinit_dout", data_out, 8'h00);
    checkOutput("midinit_rdcnt", rd_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
